// File: rtl/ram_dp_pkg.sv
// Shared types and sizing helper for the dual-port RAM and its clear engine.
package ram_dp_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } ram_dp_state_t;

  function automatic int ram_dp_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/ram_dp_clear.sv
// Clear engine: sweeps zeroes through every address after reset or on request.
// ready is low for exactly DEPTH cycles per sweep; clear is ignored while sweeping.
module ram_dp_clear
  import ram_dp_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  output logic                  ready,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  ram_dp_state_t         state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready     = 1'b0;
    clr_we    = 1'b0;
    clr_addr  = cnt;
    case (state)
      ST_CLEAR: begin
        clr_we  = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (cnt == '1) state_nxt = ST_READY;
      end
      ST_READY: begin
        ready = 1'b1;
        if (clear) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/ram_dp.sv
// Dual-port RAM: port A read/write, port B read-only, 1-cycle registered reads with valid strobes.
// A/B same-address collision is read-first unless RAM_DP_BYPASS_EN selects write-first forwarding.
module ram_dp
  import ram_dp_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  output logic                  ready,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [WIDTH-1:0]      a_wdata,
  output logic [WIDTH-1:0]      a_rdata,
  output logic                  a_rvalid,
  input  logic                  b_req,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic [WIDTH-1:0]      b_rdata,
  output logic                  b_rvalid
);

  localparam int DEPTH = ram_dp_depth(ADDR_WIDTH);

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  accept;
  logic                  a_wr, a_rd, b_rd;
  logic [WIDTH-1:0]      b_fwd;
  logic [WIDTH-1:0]      mem [DEPTH];

  ram_dp_clear #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_clear (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .ready    (ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // The edge that starts a new sweep performs no port operation.
  assign accept = ready & ~clear;
  assign a_wr   = accept & a_req & a_we;
  assign a_rd   = accept & a_req & ~a_we;
  assign b_rd   = accept & b_req;

`ifdef RAM_DP_BYPASS_EN
  assign b_fwd = (a_wr && (a_addr == b_addr)) ? a_wdata : mem[b_addr];
`else
  assign b_fwd = mem[b_addr];
`endif

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (a_wr) begin
      mem[a_addr] <= a_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata  <= '0;
      a_rvalid <= 1'b0;
      b_rdata  <= '0;
      b_rvalid <= 1'b0;
    end else begin
      a_rvalid <= a_rd;
      b_rvalid <= b_rd;
      if (a_rd) a_rdata <= mem[a_addr];
      if (b_rd) b_rdata <= b_fwd;
    end
  end

endmodule

// File: tb/tb_ram_dp.sv
// Scoreboard bench for ram_dp at WIDTH=16, ADDR_WIDTH=4.
module tb_ram_dp;

  localparam int W  = 16;
  localparam int AW = 4;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          ready;
  logic          a_req, a_we, b_req;
  logic [AW-1:0] a_addr, b_addr;
  logic [W-1:0]  a_wdata, a_rdata, b_rdata;
  logic          a_rvalid, b_rvalid;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] mdl [D];
  logic [W-1:0] a_q [$];
  logic [W-1:0] b_q [$];
  int b_run = 0;
  int b_run_max = 0;

  always #5 clk = ~clk;

  ram_dp #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .ready(ready),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_addr(b_addr), .b_rdata(b_rdata), .b_rvalid(b_rvalid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_rvalid) begin
        if (a_q.size() == 0) check("a_rvalid_unexpected", a_rvalid, 0);
        else check("a_rdata", a_rdata, a_q.pop_front());
      end
      if (b_rvalid) begin
        if (b_q.size() == 0) check("b_rvalid_unexpected", b_rvalid, 0);
        else check("b_rdata", b_rdata, b_q.pop_front());
        b_run++;
        if (b_run > b_run_max) b_run_max = b_run;
      end else begin
        b_run = 0;
      end
    end
  end

  task automatic idle();
    a_req = 1'b0; a_we = 1'b0; b_req = 1'b0;
  endtask

  // Counts negedges with ready=0; drops clear after the first one.
  task automatic wait_ready(input string tag);
    int n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      clear = 1'b0;
      if (ready) break;
      n++;
    end
    check(tag, n, D);
  endtask

  task automatic a_write(input logic [AW-1:0] ad, input logic [W-1:0] d);
    a_req = 1'b1; a_we = 1'b1; a_addr = ad; a_wdata = d;
    mdl[ad] = d;
    @(negedge clk);
    idle();
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_a_pending"}, a_q.size(), 0);
    check({tag, "_b_pending"}, b_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_a_rdata"}, a_rdata, 0);
    check({tag, "_b_rdata"}, b_rdata, 0);
    check({tag, "_a_rvalid"}, a_rvalid, 0);
    check({tag, "_b_rvalid"}, b_rvalid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; idle();
    a_addr = '0; b_addr = '0; a_wdata = '0;
    for (int i = 0; i < D; i++) mdl[i] = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");

    @(posedge clk); #1 rst_n = 1'b1;
    wait_ready("rst_ready_low_cycles");

    // Whole array reads zero after the sweep, back-to-back on B.
    for (int i = 0; i < D; i++) begin
      b_req = 1'b1; b_addr = AW'(i); b_q.push_back(16'h0000);
      @(negedge clk);
    end
    idle();
    repeat (2) @(negedge clk);
    check_empty("zero");

    // Write then simultaneous A/B read.
    a_write(4'd5, 16'hBEEF);
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd5; a_q.push_back(mdl[5]);
    b_req = 1'b1; b_addr = 4'd5; b_q.push_back(mdl[5]);
    @(negedge clk);
    idle();
    repeat (2) @(negedge clk);
    check_empty("wr_rd");

    // A write and B read of the same address on one edge.
    a_write(4'd3, 16'h1111);
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd3; a_wdata = 16'h2222;
    b_req = 1'b1; b_addr = 4'd3;
`ifdef RAM_DP_BYPASS_EN
    b_q.push_back(16'h2222);
`else
    b_q.push_back(16'h1111);
`endif
    mdl[3] = 16'h2222;
    @(negedge clk);
    idle();
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd3; a_q.push_back(mdl[3]);
    @(negedge clk);
    idle();
    repeat (2) @(negedge clk);
    check_empty("collide");

    // Requests and a second clear during a sweep are all dropped.
    a_write(4'd7, 16'hAAAA);
    clear = 1'b1;
    begin
      int n = 0;
      for (int i = 0; i < 64; i++) begin
        @(negedge clk);
        clear = 1'b0; idle();
        if (ready) break;
        n++;
        if (n >= 9 && n <= 14) begin
          a_req = 1'b1; a_we = 1'b1; a_addr = 4'd7; a_wdata = 16'h5555;
          b_req = 1'b1; b_addr = 4'd7;
        end
        if (n == 12) clear = 1'b1;
      end
      idle(); clear = 1'b0;
      check("busy_ready_low_cycles", n, D);
    end
    for (int i = 0; i < D; i++) mdl[i] = '0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd7; a_q.push_back(16'h0000);
    b_req = 1'b1; b_addr = 4'd3; b_q.push_back(16'h0000);
    @(negedge clk);
    idle();
    repeat (2) @(negedge clk);
    check_empty("busy");

    // Back-to-back writes, then 16 consecutive B reads in address order.
    for (int i = 0; i < D; i++) begin
      a_req = 1'b1; a_we = 1'b1; a_addr = AW'(i); a_wdata = 16'hC000 + W'(i * 37);
      mdl[i] = 16'hC000 + W'(i * 37);
      @(negedge clk);
    end
    idle();
    @(negedge clk);
    b_run_max = 0;
    for (int i = 0; i < D; i++) begin
      b_req = 1'b1; b_addr = AW'(i); b_q.push_back(mdl[i]);
      @(negedge clk);
    end
    idle();
    repeat (2) @(negedge clk);
    check("b2b_rvalid_run", b_run_max, D);
    check_empty("b2b");

    // Reset asserted with the sweep counter at 9.
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd2; a_q.push_back(mdl[2]);
    b_req = 1'b1; b_addr = 4'd4; b_q.push_back(mdl[4]);
    @(negedge clk);
    idle();
    repeat (2) @(negedge clk);
    check_empty("pre_rst");
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1 rst_n = 1'b1;
    wait_ready("midrst_ready_low_cycles");
    b_req = 1'b1; b_addr = 4'd15; b_q.push_back(16'h0000);
    @(negedge clk);
    idle();
    repeat (2) @(negedge clk);
    check_empty("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_dp.md
# ram_dp

Parametrised dual-port synchronous RAM for the CPU data path. It replaces the single-port combinational-read memory with:
- port A: read/write, used by the CPU data bus;
- port B: read-only, used by display/debug readout.

Both ports have registered reads with a valid strobe. A built-in clear engine zeroes the whole array after reset or on request, so the CPU never sees undefined memory.

## Interface
Parameters:
- WIDTH, 16, data word width in bits (≥1)
- ADDR_WIDTH, 14, address width; DEPTH = 2**ADDR_WIDTH words, every address valid

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  pulse: start a full zeroing sweep (honoured only when ready=1)
- ready  out  1  1 = ports accept requests; 0 = clear sweep in progress
- a_req  in  1  port A request, sampled on clk when ready=1
- a_we  in  1  with a_req: 1 = write, 0 = read
- a_addr  in  ADDR_WIDTH  port A address
- a_wdata  in  WIDTH  port A write data
- a_rdata  out  WIDTH  port A read data
- a_rvalid  out  1  one-cycle strobe: a_rdata updated by an accepted read
- b_req  in  1  port B read request, sampled on clk when ready=1
- b_addr  in  ADDR_WIDTH  port B address
- b_rdata  out  WIDTH  port B read data
- b_rvalid  out  1  one-cycle strobe: b_rdata updated by an accepted read

## Operation
- FSM states are ST_CLEAR and ST_READY. Reset enters ST_CLEAR with sweep counter = 0.
- In ST_CLEAR:
  - each edge writes 0 to mem[counter] and increments the counter;
  - on the edge that writes DEPTH-1, go to ST_READY.
- In ST_READY, clear=1 at an edge returns to ST_CLEAR with counter = 0. No port operation is performed on that edge.
- While ready=0:
  - a_req and b_req are ignored (dropped, no strobe; the requester must retry);
  - clear is ignored; an ongoing sweep is never restarted.
- Port A write (a_req=1, a_we=1): mem[a_addr] ← a_wdata at the edge. a_rvalid stays 0 and a_rdata is unchanged.
- Port A read (a_req=1, a_we=0): a_rdata ← mem[a_addr] at the edge, a_rvalid=1 for the following cycle.
- Port B read: same as a port A read, on b_*.
- rdata holds its last value until the next accepted read on that port. rvalid is 0 on any cycle without a newly accepted read.
- Both ports may be accepted on the same edge, including the same address.
- Reset values: ready=0, a_rdata=0, b_rdata=0, a_rvalid=0, b_rvalid=0.
- Array contents are not reset directly. They are guaranteed zero only once the sweep completes.

## Timing
- Read latency is 1 cycle: request at edge k → data and rvalid valid after edge k, sampled at edge k+1.
- Full throughput: one request per port per cycle.
- Clear duration: the first edge after rst_n deasserts writes address 0. ready rises after the DEPTH-th edge, i.e. DEPTH cycles of ready=0.
- A clear request at edge k drops ready after edge k, for DEPTH cycles.
- Reset asserted mid-sweep or mid-operation: all outputs immediately take their reset values. FSM returns to ST_CLEAR, counter = 0, and the sweep restarts from 0 after deassertion.
- Same-address collision between a port A write and a port B read on the same edge: behaviour is set by the macro below.

## Configuration
- Macro: RAM_DP_BYPASS_EN.
- Defined: write-first forwarding. b_rdata returns the a_wdata being written on that edge.
- Undefined: read-first. b_rdata returns the value stored before the write. This maps directly to block RAM with no forwarding mux.

## Structure
- Package ram_dp_pkg holds:
  - the state typedef ram_dp_state_t {ST_CLEAR, ST_READY};
  - the localparam helper for DEPTH from ADDR_WIDTH.
- One sub-module, ram_dp_clear: holds the FSM and sweep counter, and outputs ready, the clear write enable and the clear address.
- The top level muxes the clear-engine write against the port A write, and instantiates the array and both read registers.

## Test plan
The bench uses WIDTH=16, ADDR_WIDTH=4 (DEPTH=16).
- Reset release:
  - ready=0 for exactly 16 cycles, then 1;
  - all outputs 0 during reset;
  - reading all 16 addresses on port B afterwards returns 0x0000.
- Write/read: A writes 0xBEEF to addr 5; next cycle A reads 5 and B reads 5 → both return 0xBEEF, both rvalid=1 for exactly one cycle.
- Collision: mem[3]=0x1111; A writes 0x2222 to 3 while B reads 3 on the same edge → b_rdata=0x2222 with RAM_DP_BYPASS_EN, 0x1111 without.
- Requests while busy: clear pulse with mem[7]=0xAAAA; A writes 0x5555 to 7 during the sweep → no rvalid on any port; after ready=1, a read of 7 returns 0x0000.
- Reset mid-sweep: assert rst_n=0 at sweep counter 9 → outputs 0 at once; after release, ready=0 for a full 16 cycles.
- Back-to-back: B reads addresses 0..15 consecutively with ready=1 → 16 consecutive rvalid cycles, data in address order.
